// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU: opcode encoding,
// handshake FSM states and bit positions inside the flag vector.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'b0000,
        OP_SUB = 4'b0001,
        OP_MUL = 4'b0010,
        OP_DIV = 4'b0011,
        OP_SHL = 4'b0100,
        OP_SHR = 4'b0101,
        OP_AND = 4'b1000,
        OP_OR  = 4'b1001,
        OP_XOR = 4'b1010
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int FLG_Z  = 0;
    localparam int FLG_N  = 1;
    localparam int FLG_C  = 2;
    localparam int FLG_V  = 3;
    localparam int FLG_DZ = 4;

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative multiplier (shift-add) and divider (restoring), one bit per
// cycle. The first iteration happens on the start edge itself, so after
// WIDTH-1 further edges the results are final and done is raised while the
// counter sits at WIDTH-1.
module alu_iter_muldiv import alu_pkg::*; #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] prod_lo,
    output logic [WIDTH-1:0] prod_hi,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic          busy;
    logic [CW-1:0] cnt;
    logic          div_q;
    logic          step;

    logic [WIDTH-1:0] hi_q, lo_q, mc_q, quot_q, rem_q, dvs_q;
    logic [WIDTH-1:0] hi_s, lo_s, mc_s, quot_s, rem_s, dvs_s;
    logic             div_s;
    logic [WIDTH:0]   msum, shifted, trial;
    logic [WIDTH-1:0] hi_n, lo_n, quot_n, rem_n;

    assign done = busy && (cnt == LAST);
    assign step = start || (busy && (cnt != LAST));

    assign prod_lo = lo_q;
    assign prod_hi = hi_q;
    assign quot    = quot_q;
    assign rem     = rem_q;

    // One iteration step, fed from fresh operands on start or from the registers otherwise
    always_comb begin
        hi_s   = start ? '0     : hi_q;
        lo_s   = start ? b      : lo_q;
        mc_s   = start ? a      : mc_q;
        rem_s  = start ? '0     : rem_q;
        quot_s = start ? a      : quot_q;
        dvs_s  = start ? b      : dvs_q;
        div_s  = start ? op_div : div_q;

        msum = {1'b0, hi_s} + (lo_s[0] ? {1'b0, mc_s} : '0);
        hi_n = msum[WIDTH:1];
        lo_n = {msum[0], lo_s[WIDTH-1:1]};

        shifted = {rem_s, quot_s[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_s};
        if (trial[WIDTH]) begin
            rem_n  = shifted[WIDTH-1:0];
            quot_n = {quot_s[WIDTH-2:0], 1'b0};
        end else begin
            rem_n  = trial[WIDTH-1:0];
            quot_n = {quot_s[WIDTH-2:0], 1'b1};
        end
    end

    // Iteration counter and busy flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= 1'b0;
            cnt   <= '0;
            div_q <= 1'b0;
        end else if (start) begin
            busy  <= 1'b1;
            cnt   <= '0;
            div_q <= op_div;
        end else if (busy) begin
            if (cnt == LAST) begin
                busy <= 1'b0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Accumulator and division registers; only the selected datapath moves
    always_ff @(posedge clk) begin
        if (step && !div_s) begin
            hi_q <= hi_n;
            lo_q <= lo_n;
            mc_q <= mc_s;
        end
        if (step && div_s) begin
            quot_q <= quot_n;
            rem_q  <= rem_n;
            dvs_q  <= dvs_s;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes. Single-cycle ops are computed
// straight from the inputs on the accept edge; MUL and DIV run in the
// iterative sub-unit. Results and flags are held until the consumer takes them.
module alu_seq import alu_pkg::*; #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder,
    output logic [4:0]       flags
);

    localparam int SW = $clog2(WIDTH);

    state_e state;
    logic   accept;
    logic   is_mul, is_div, div_zero, go_iter;
    logic   op_div_q;

    logic [WIDTH-1:0] res1, rem1;
    logic             c1, v1, dz1;
    logic [WIDTH:0]   sum_w, diff_w, shl_w, shr_w;
    logic [SW-1:0]    amt;

    logic             md_done;
    logic [WIDTH-1:0] prod_lo, prod_hi, quot, rem;
    logic             mul_ovf;

    function automatic logic [4:0] mk_flags(input logic [WIDTH-1:0] r, input logic c,
                                            input logic v, input logic dz);
        logic [4:0] f;
        f         = '0;
        f[FLG_Z]  = (r == '0);
        f[FLG_N]  = r[WIDTH-1];
        f[FLG_C]  = c;
        f[FLG_V]  = v;
        f[FLG_DZ] = dz;
        return f;
    endfunction

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign is_mul    = (opcode == OP_MUL);
    assign is_div    = (opcode == OP_DIV);
    assign div_zero  = is_div && (b == '0);
    assign go_iter   = accept && (is_mul || (is_div && !div_zero));
    assign mul_ovf   = |prod_hi;

    alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (go_iter),
        .op_div  (is_div),
        .a       (a),
        .b       (b),
        .done    (md_done),
        .prod_lo (prod_lo),
        .prod_hi (prod_hi),
        .quot    (quot),
        .rem     (rem)
    );

    // Single-cycle datapath, including the divide-by-zero shortcut
    always_comb begin
        amt    = b[SW-1:0];
        sum_w  = {1'b0, a} + {1'b0, b};
        diff_w = {1'b0, a} - {1'b0, b};
        shl_w  = {1'b0, a} << amt;
        shr_w  = {a, 1'b0} >> amt;
        res1   = '0;
        rem1   = '0;
        c1     = 1'b0;
        v1     = 1'b0;
        dz1    = 1'b0;
        case (opcode)
            OP_ADD: begin
                res1 = sum_w[WIDTH-1:0];
                c1   = sum_w[WIDTH];
                v1   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                res1 = diff_w[WIDTH-1:0];
                c1   = diff_w[WIDTH];
                v1   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_MUL: res1 = '0;
            OP_DIV: begin
                res1 = '1;
                rem1 = a;
                dz1  = 1'b1;
            end
            OP_SHL: begin
                res1 = shl_w[WIDTH-1:0];
                c1   = shl_w[WIDTH];
            end
            OP_SHR: begin
                res1 = shr_w[WIDTH:1];
                c1   = shr_w[0];
            end
            OP_OR:   res1 = a | b;
            OP_XOR:  res1 = a ^ b;
            default: res1 = a & b;
        endcase
    end

    // Handshake FSM and output registers; flags load only on entry to DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            result    <= '0;
            remainder <= '0;
            flags     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (go_iter) begin
                            state <= CALC;
                        end else begin
                            state     <= DONE;
                            result    <= res1;
                            remainder <= rem1;
                            flags     <= mk_flags(res1, c1, v1, dz1);
                        end
                    end
                end
                CALC: begin
                    if (md_done) begin
                        state <= DONE;
                        if (op_div_q) begin
                            result    <= quot;
                            remainder <= rem;
                            flags     <= mk_flags(quot, 1'b0, 1'b0, 1'b0);
                        end else begin
                            result    <= prod_lo;
                            remainder <= '0;
                            flags     <= mk_flags(prod_lo, mul_ovf, mul_ovf, 1'b0);
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Remember which iterative result to pick up when the sub-unit finishes
    always_ff @(posedge clk) begin
        if (accept) begin
            op_div_q <= is_div;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8: a vector table for the single
// operations plus hand-written backpressure and mid-operation reset sequences.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [3:0] opcode = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] result;
    logic [7:0] remainder;
    logic [4:0] flags;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string      name;
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic [7:0] rem;
        logic [4:0] flg;
        int         lat;
    } vec_t;

    vec_t vecs[17];

    alu_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .remainder (remainder),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Present one operation, wait (bounded) for out_valid; lat counts edges from the accept edge
    task automatic run_op(input logic [3:0] op, input logic [7:0] av, input logic [7:0] bv,
                          output int lat);
        @(negedge clk);
        opcode   = op;
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic drain();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;

        //                name         op       a      b      res    rem    {DZ,V,C,N,Z} lat
        vecs[0]  = '{"add_ff_01",  4'h0, 8'hFF, 8'h01, 8'h00, 8'h00, 5'b00101, 1};
        vecs[1]  = '{"sub_80_01",  4'h1, 8'h80, 8'h01, 8'h7F, 8'h00, 5'b01000, 1};
        vecs[2]  = '{"sub_03_05",  4'h1, 8'h03, 8'h05, 8'hFE, 8'h00, 5'b00110, 1};
        vecs[3]  = '{"mul_15_17",  4'h2, 8'd15, 8'd17, 8'hFF, 8'h00, 5'b00010, 9};
        vecs[4]  = '{"mul_16_16",  4'h2, 8'd16, 8'd16, 8'h00, 8'h00, 5'b01101, 9};
        vecs[5]  = '{"div_200_7",  4'h3, 8'd200, 8'd7, 8'd28, 8'd4,  5'b00000, 9};
        vecs[6]  = '{"div_9_0",    4'h3, 8'h09, 8'h00, 8'hFF, 8'h09, 5'b10010, 1};
        vecs[7]  = '{"op_f_and",   4'hF, 8'hF0, 8'h3C, 8'h30, 8'h00, 5'b00000, 1};
        vecs[8]  = '{"add_7f_01",  4'h0, 8'h7F, 8'h01, 8'h80, 8'h00, 5'b01010, 1};
        vecs[9]  = '{"shl_81_1",   4'h4, 8'h81, 8'h01, 8'h02, 8'h00, 5'b00100, 1};
        vecs[10] = '{"shr_81_1",   4'h5, 8'h81, 8'h01, 8'h40, 8'h00, 5'b00100, 1};
        vecs[11] = '{"shl_amt0",   4'h4, 8'h81, 8'h08, 8'h81, 8'h00, 5'b00010, 1};
        vecs[12] = '{"shr_80_7",   4'h5, 8'h80, 8'h07, 8'h01, 8'h00, 5'b00000, 1};
        vecs[13] = '{"or_0f_f0",   4'h9, 8'h0F, 8'hF0, 8'hFF, 8'h00, 5'b00010, 1};
        vecs[14] = '{"xor_aa_aa",  4'hA, 8'hAA, 8'hAA, 8'h00, 8'h00, 5'b00001, 1};
        vecs[15] = '{"div_5_9",    4'h3, 8'd5,  8'd9,  8'h00, 8'd5,  5'b00001, 9};
        vecs[16] = '{"mul_0f_0e",  4'h2, 8'h0F, 8'h0E, 8'hD2, 8'h00, 5'b00010, 9};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_result",    32'(result),    32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_flags",     32'(flags),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // Vector table
        for (int i = 0; i < 17; i++) begin
            check({vecs[i].name, "_in_ready"}, 32'(in_ready), 32'd1);
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
            check({vecs[i].name, "_latency"}, 32'(lat),       32'(vecs[i].lat));
            check({vecs[i].name, "_result"},  32'(result),    32'(vecs[i].res));
            check({vecs[i].name, "_rem"},     32'(remainder), 32'(vecs[i].rem));
            check({vecs[i].name, "_flags"},   32'(flags),     32'(vecs[i].flg));
            drain();
            check({vecs[i].name, "_release"}, 32'(out_valid), 32'd0);
        end

        // Backpressure after MUL 3*5, with a competing request held on the input
        run_op(4'h2, 8'd3, 8'd5, lat);
        check("bp_latency", 32'(lat), 32'd9);
        @(negedge clk);
        opcode   = 4'h0;
        a        = 8'd1;
        b        = 8'd1;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_result",    32'(result),    32'd15);
            check("bp_in_ready",  32'(in_ready),  32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_after_ready_valid", 32'(out_valid), 32'd0);
        check("bp_after_ready_rdy",   32'(in_ready),  32'd1);
        check("bp_after_ready_res",   32'(result),    32'd15);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_next_valid",  32'(out_valid), 32'd1);
        check("bp_next_result", 32'(result),    32'd2);
        drain();

        // Reset in the middle of a DIV
        @(negedge clk);
        opcode   = 4'h3;
        a        = 8'd200;
        b        = 8'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("mid_calc_in_ready", 32'(in_ready), 32'd0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready",  32'(in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            check("post_rst_out_valid", 32'(out_valid), 32'd0);
            check("post_rst_in_ready",  32'(in_ready),  32'd1);
        end
        check("post_rst_result",    32'(result),    32'd0);
        check("post_rst_remainder", 32'(remainder), 32'd0);
        check("post_rst_flags",     32'(flags),     32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
